// File: rtl/serial_ge_comparator.sv
// serial_ge_comparator: bit-serial magnitude comparator, LSB-first.
// Captures a/b on an accepted start and consumes one bit pair per clock.
// After WIDTH bit cycles it pulses done and presents ge/gt/eq, which hold
// until the next done. Any differing bit overrides the verdict of the lower
// bits, so after the MSB the accumulator holds the full comparison.
// Optional build macro SERIAL_CMP_SIGNED_EN: two's-complement operands. On
// the MSB cycle a differing bit is taken with inverted sense.
module serial_ge_comparator #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic             ge,
    output logic             gt,
    output logic             eq
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             acc_gt_q, acc_gt_d;
    logic             acc_eq_q, acc_eq_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             ge_q, ge_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;

    logic             bit_x;
    logic             bit_y;
    logic             last_bit;
    logic             accept;
    logic             diff_gt;

    assign bit_x    = sa_q[0];
    assign bit_y    = sb_q[0];
    assign last_bit = (count_q == LAST_BIT);
    assign accept   = (state_q == ST_IDLE) && start;

    // Verdict of a differing bit pair; the signed MSB flips the sense.
`ifdef SERIAL_CMP_SIGNED_EN
    assign diff_gt = last_bit ? bit_y : bit_x;
`else
    assign diff_gt = bit_x;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> SHIFT -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: registered handshake and result flags.
    always_comb begin
        ready_d = (state_d == ST_IDLE);
        done_d  = 1'b0;
        ge_d    = ge_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        if (state_q == ST_DONE) begin
            done_d = 1'b1;
            gt_d   = acc_gt_q;
            eq_d   = acc_eq_q;
            ge_d   = acc_gt_q | acc_eq_q;
        end
    end

    // Datapath next values: operand capture, shift, bit accumulation.
    always_comb begin
        sa_d     = sa_q;
        sb_d     = sb_q;
        count_d  = count_q;
        acc_gt_d = acc_gt_q;
        acc_eq_d = acc_eq_q;
        if (accept) begin
            sa_d     = a;
            sb_d     = b;
            count_d  = '0;
            acc_gt_d = 1'b0;
            acc_eq_d = 1'b1;
        end else if (state_q == ST_SHIFT) begin
            if (bit_x != bit_y) begin
                acc_gt_d = diff_gt;
                acc_eq_d = 1'b0;
            end
            sa_d    = sa_q >> 1;
            sb_d    = sb_q >> 1;
            count_d = count_q + CNT_W'(1);
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q     <= '0;
            sb_q     <= '0;
            count_q  <= '0;
            acc_gt_q <= 1'b0;
            acc_eq_q <= 1'b1;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            ge_q     <= 1'b1;
            gt_q     <= 1'b0;
            eq_q     <= 1'b1;
        end else begin
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            count_q  <= count_d;
            acc_gt_q <= acc_gt_d;
            acc_eq_q <= acc_eq_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            ge_q     <= ge_d;
            gt_q     <= gt_d;
            eq_q     <= eq_d;
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign ge    = ge_q;
    assign gt    = gt_q;
    assign eq    = eq_q;

endmodule

// File: tb/tb_serial_ge_comparator.sv
// Testbench for serial_ge_comparator: directed cases plus random compares
// against an arithmetic reference model.
module tb_serial_ge_comparator;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         done;
    logic         ge;
    logic         gt;
    logic         eq;

    int n_checks;
    int n_fail;
    int cyc;
    logic prev_ge, prev_gt, prev_eq;

    serial_ge_comparator #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .done  (done),
        .ge    (ge),
        .gt    (gt),
        .eq    (eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: plain arithmetic comparison, signed when the macro is set.
    function automatic logic [2:0] model(input logic [W-1:0] av, input logic [W-1:0] bv);
        logic g, e;
`ifdef SERIAL_CMP_SIGNED_EN
        g = $signed(av) > $signed(bv);
`else
        g = av > bv;
`endif
        e = (av == bv);
        return {g | e, g, e};
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check({tag, "_done"},  32'(done),  32'd0);
        check({tag, "_flags"}, 32'({ge, gt, eq}), 32'(3'b101));
    endtask

    // One full compare: wait for ready, pulse start, verify latency and result.
    task automatic do_cmp(input logic [W-1:0] av, input logic [W-1:0] bv, input string tag);
        logic [2:0] exp;
        int lat;
        bit got_ready;
        got_ready = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready) begin
                got_ready = 1;
                break;
            end
        end
        check({tag, "_ready_wait"}, 32'(got_ready), 32'd1);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy"}, 32'(ready), 32'd0);
        lat = 0;
        for (int i = 0; i < int'(W) + 4; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            lat++;
            if (i == 0) lat = 0;
            if (done) break;
            check({tag, "_hold"}, 32'({ge, gt, eq}), 32'({prev_ge, prev_gt, prev_eq}));
        end
        check({tag, "_latency"}, 32'(lat), 32'(W + 1));
        exp = model(av, bv);
        check({tag, "_result"}, 32'({ge, gt, eq}), 32'(exp));
        check({tag, "_inv"}, 32'(ge), 32'(gt | eq));
        {prev_ge, prev_gt, prev_eq} = exp;
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(ready), 32'd1);
    endtask

    initial begin
        int d1, d2;
        bit seen;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        {prev_ge, prev_gt, prev_eq} = 3'b101;

        // Reset values, then idle hold after release.
        rst_n = 1'b0;
        #12;
        check_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst_hold");

        // Directed compares.
        do_cmp(4'b1001, 4'b0110, "msb_over_lsb");
        do_cmp(4'b0101, 4'b0101, "equal");
        do_cmp(4'd3, 4'd12, "less");
        do_cmp(4'b1111, 4'b0001, "sign_case");
`ifdef SERIAL_CMP_SIGNED_EN
        check("sign_case_gt", 32'(gt), 32'd0);
`else
        check("sign_case_gt", 32'(gt), 32'd1);
`endif

        // Reset during the second shift bit aborts without done.
        @(negedge clk);
        a = 4'd9;
        b = 4'd4;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check_reset_vals("mid_rst");
        {prev_ge, prev_gt, prev_eq} = 3'b101;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < int'(W) + 4; i++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1;
        end
        check("mid_rst_no_done", 32'(seen), 32'd0);
        check("mid_rst_flags", 32'({ge, gt, eq}), 32'(3'b101));
        do_cmp(4'd7, 4'd2, "after_rst");

        // Start held high across two back-to-back compares.
        @(negedge clk);
        a = 4'd2;
        b = 4'd2;
        start = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1;
                break;
            end
        end
        d1 = cyc;
        check("held1_seen", 32'(seen), 32'd1);
        check("held1_result", 32'({ge, gt, eq}), 32'(model(4'd2, 4'd2)));
        a = 4'd1;
        b = 4'd8;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1;
                break;
            end
        end
        d2 = cyc;
        start = 1'b0;
        check("held2_seen", 32'(seen), 32'd1);
        check("held_spacing", 32'(d2 - d1), 32'(W + 2));
        check("held2_result", 32'({ge, gt, eq}), 32'(model(4'd1, 4'd8)));
        {prev_ge, prev_gt, prev_eq} = model(4'd1, 4'd8);

        // Random compares against the model.
        for (int n = 0; n < 40; n++) begin
            do_cmp(W'($urandom), W'($urandom), "rand");
        end
        do_cmp(4'd0, 4'd15, "edge_min_max");
        do_cmp(4'd15, 4'd0, "edge_max_min");
        do_cmp(4'd8, 4'd7, "edge_msb_only");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
